// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the BCD stopwatch/timer.
// Field offsets describe the packed time {MINUTES, SEC_MSB, SEC_LSB, TENTHS}.
package stopwatch_pkg;

    localparam logic [3:0] BCD_MAX_9 = 4'd9;
    localparam logic [3:0] BCD_MAX_5 = 4'd5;

    localparam int TENTHS_LO = 0;
    localparam int SECL_LO   = 4;
    localparam int SECM_LO   = 8;
    localparam int MIN_LO    = 12;

    function automatic logic [3:0] bcd_sat(
        input logic [3:0] d,
        input logic [3:0] max
    );
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with load, up/down count and wrap at a programmable max.
// Carry/borrow-out is combinational so a whole chain steps in one tick.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] max,
    output logic [3:0] q,
    output logic       co
);

    assign co = en & (up ? (q == max) : (q == 4'd0));

    // digit register: load wins over count, wrap at max / zero
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (up) begin
                q <= (q == max) ? 4'd0 : q + 4'd1;
            end else begin
                q <= (q == 4'd0) ? max : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_cnt.sv
// Parametrised BCD stopwatch/timer: tenths, seconds, N-digit minutes.
// Up/down count, sanitised preset load, lap capture, WRAP and DONE flags.
module stopwatch_cnt
    import stopwatch_pkg::*;
#(
    parameter int MIN_DIGITS = 2,
    parameter int MIN_LIMIT  = 59,
    parameter bit TENTHS_EN  = 1'b1,
    parameter int TW         = 12 + 4 * MIN_DIGITS
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic                    CE,
    input  logic                    UP,
    input  logic                    LOAD,
    input  logic [TW-1:0]           LOAD_VAL,
    input  logic                    LAP,
    output logic [3:0]              TENTHS,
    output logic [3:0]              SEC_LSB,
    output logic [3:0]              SEC_MSB,
    output logic [4*MIN_DIGITS-1:0] MINUTES,
    output logic [TW-1:0]           LAP_TIME,
    output logic                    WRAP,
    output logic                    DONE
);

    localparam int MW = 4 * MIN_DIGITS;

    function automatic logic [MW-1:0] to_bcd(input int v);
        logic [MW-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [MW-1:0] LIM = to_bcd(MIN_LIMIT);

    logic [3:0]          ten_q, sl_q, sm_q;
    logic [MW-1:0]       min_q;
    logic                ten_co, sl_co, sm_co;
    logic [MIN_DIGITS:0] min_c;
    logic                is_zero, is_one, low_one, tick;
    logic                min_at, min_wrap, min_ld;
    logic [3:0]          ld_ten, ld_sl, ld_sm;
    logic [MW-1:0]       ld_min_raw, ld_min, min_ld_val;
    logic [TW-1:0]       cur;
    logic                wrap_q, done_q;
    logic [TW-1:0]       lap_q;
    logic                carry_unused;

    // clamp every preset field to its legal range
    always_comb begin
        ld_ten = TENTHS_EN ? bcd_sat(LOAD_VAL[TENTHS_LO +: 4], BCD_MAX_9)
                           : 4'd0;
        ld_sl = bcd_sat(LOAD_VAL[SECL_LO +: 4], BCD_MAX_9);
        ld_sm = bcd_sat(LOAD_VAL[SECM_LO +: 4], BCD_MAX_5);
        ld_min_raw = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            ld_min_raw[4*i +: 4] =
                bcd_sat(LOAD_VAL[MIN_LO + 4*i +: 4], BCD_MAX_9);
        end
        ld_min = (ld_min_raw > LIM) ? LIM : ld_min_raw;
    end

    assign cur = {min_q, 1'b0, sm_q[2:0], sl_q, ten_q};

    assign is_zero = (ten_q == 4'd0) && (sl_q == 4'd0)
                  && (sm_q == 4'd0) && (min_q == '0);
    assign low_one = TENTHS_EN ? ((ten_q == 4'd1) && (sl_q == 4'd0))
                               : (sl_q == 4'd1);
    assign is_one = low_one && (sm_q == 4'd0) && (min_q == '0);

    // a down-count at zero must not borrow around to MAX
    assign tick = CE & ~LOAD & (UP | ~is_zero);

    generate
        if (TENTHS_EN) begin : g_ten
            bcd_digit u_ten (
                .CLK      (CLK),
                .CLR      (CLR),
                .en       (tick),
                .up       (UP),
                .load     (LOAD),
                .load_val (ld_ten),
                .max      (BCD_MAX_9),
                .q        (ten_q),
                .co       (ten_co)
            );
        end else begin : g_no_ten
            logic ten_unused;
            assign ten_unused = ^ld_ten;
            assign ten_q  = 4'd0;
            assign ten_co = tick;
        end
    endgenerate

    bcd_digit u_sec_lsb (
        .CLK      (CLK),
        .CLR      (CLR),
        .en       (ten_co),
        .up       (UP),
        .load     (LOAD),
        .load_val (ld_sl),
        .max      (BCD_MAX_9),
        .q        (sl_q),
        .co       (sl_co)
    );

    bcd_digit u_sec_msb (
        .CLK      (CLK),
        .CLR      (CLR),
        .en       (sl_co),
        .up       (UP),
        .load     (LOAD),
        .load_val (ld_sm),
        .max      (BCD_MAX_5),
        .q        (sm_q),
        .co       (sm_co)
    );

    // minutes wrap at the decimal limit, not at 99..9: force via load
    assign min_at     = UP ? (min_q == LIM) : (min_q == '0);
    assign min_wrap   = sm_co & min_at;
    assign min_ld     = LOAD | min_wrap;
    assign min_ld_val = LOAD ? ld_min : (UP ? '0 : LIM);
    assign min_c[0]   = sm_co;

    generate
        for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
            bcd_digit u_min (
                .CLK      (CLK),
                .CLR      (CLR),
                .en       (min_c[i]),
                .up       (UP),
                .load     (min_ld),
                .load_val (min_ld_val[4*i +: 4]),
                .max      (BCD_MAX_9),
                .q        (min_q[4*i +: 4]),
                .co       (min_c[i+1])
            );
        end
    endgenerate

    assign carry_unused = min_c[MIN_DIGITS];

    // rollover pulse, terminal-count level and lap snapshot
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            lap_q  <= '0;
        end else begin
            if (LAP) begin
                lap_q <= cur;
            end
            wrap_q <= ~LOAD & CE & UP & min_wrap;
            if (LOAD) begin
                done_q <= 1'b0;
            end else if (CE) begin
                done_q <= ~UP & (is_zero | is_one);
            end
        end
    end

    assign TENTHS   = ten_q;
    assign SEC_LSB  = sl_q;
    assign SEC_MSB  = {1'b0, sm_q[2:0]};
    assign MINUTES  = min_q;
    assign LAP_TIME = lap_q;
    assign WRAP     = wrap_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_stopwatch_cnt.sv
// Bench for stopwatch_cnt: time held as an integer count of tenths,
// directed scenarios plus a randomised run, checked every cycle.
module tb_stopwatch_cnt;

    localparam int MLIM = 59;
    localparam int MAXT = (MLIM * 60 + 59) * 10 + 9;

    logic        CLK, CLR, CE, UP, LOAD, LAP;
    logic [19:0] LOAD_VAL;
    logic [3:0]  TENTHS, SEC_LSB, SEC_MSB;
    logic [7:0]  MINUTES;
    logic [19:0] LAP_TIME;
    logic        WRAP, DONE;

    int n_chk = 0;
    int n_pass = 0;
    bit armed = 0;

    int   m_t, m_lap;
    logic m_wrap, m_done;

    stopwatch_cnt dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .CE       (CE),
        .UP       (UP),
        .LOAD     (LOAD),
        .LOAD_VAL (LOAD_VAL),
        .LAP      (LAP),
        .TENTHS   (TENTHS),
        .SEC_LSB  (SEC_LSB),
        .SEC_MSB  (SEC_MSB),
        .MINUTES  (MINUTES),
        .LAP_TIME (LAP_TIME),
        .WRAP     (WRAP),
        .DONE     (DONE)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    function automatic logic [19:0] pk(input int t);
        int m, s;
        m = t / 600;
        s = (t / 10) % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(t % 10)};
    endfunction

    function automatic int clamp(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic int san(input logic [19:0] v);
        int te, sl, sm, m;
        te = clamp(int'(v[3:0]), 9);
        sl = clamp(int'(v[7:4]), 9);
        sm = clamp(int'(v[11:8]), 5);
        m  = clamp(int'(v[19:16]), 9) * 10 + clamp(int'(v[15:12]), 9);
        m  = clamp(m, MLIM);
        return (m * 60 + sm * 10 + sl) * 10 + te;
    endfunction

    function automatic logic [19:0] now_time();
        return {MINUTES, SEC_MSB, SEC_LSB, TENTHS};
    endfunction

    task automatic chk(input string nm, input logic [19:0] act,
                       input logic [19:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp,
                     $time);
        else
            n_pass++;
    endtask

    // reference: elapsed tenths as a plain integer
    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m_t <= 0;
            m_lap <= 0;
            m_wrap <= 0;
            m_done <= 0;
        end else begin
            if (LAP) m_lap <= m_t;
            m_wrap <= 0;
            if (LOAD) begin
                m_t <= san(LOAD_VAL);
                m_done <= 0;
            end else if (CE && UP) begin
                m_t <= (m_t == MAXT) ? 0 : m_t + 1;
                m_wrap <= (m_t == MAXT);
                m_done <= 0;
            end else if (CE) begin
                m_t <= (m_t == 0) ? 0 : m_t - 1;
                m_done <= (m_t <= 1);
            end
        end
    end

    // compare against the reference every cycle
    always @(negedge CLK) begin
        if (armed && !CLR) begin
            chk("time", now_time(), pk(m_t));
            chk("lap", LAP_TIME, pk(m_lap));
            chk("wrap", {19'd0, WRAP}, {19'd0, m_wrap});
            chk("done", {19'd0, DONE}, {19'd0, m_done});
        end
    end

    task automatic tick(input logic ce, input logic up, input logic ld,
                        input logic [19:0] lv, input logic lp);
        CE = ce;
        UP = up;
        LOAD = ld;
        LOAD_VAL = lv;
        LAP = lp;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        CLR = 0;
        CE = 0;
        UP = 1;
        LOAD = 0;
        LAP = 0;
        LOAD_VAL = '0;
        #2 CLR = 1;
        #1;
        chk("rst_time", now_time(), 20'h00000);
        chk("rst_lap", LAP_TIME, 20'h00000);
        chk("rst_wrap", {19'd0, WRAP}, 20'h0);
        chk("rst_done", {19'd0, DONE}, 20'h0);
        #5 CLR = 0;
        armed = 1;

        // 600 up ticks -> 1:00.0
        for (int i = 0; i < 600; i++) tick(1, 1, 0, '0, 0);
        chk("t1_time", now_time(), 20'h01000);
        chk("t1_wrap", {19'd0, WRAP}, 20'h0);

        // rollover from 59:59.9
        tick(0, 1, 1, 20'h59599, 0);
        chk("t2_load", now_time(), 20'h59599);
        tick(1, 1, 0, '0, 0);
        chk("t2_time", now_time(), 20'h00000);
        chk("t2_wrap", {19'd0, WRAP}, 20'h1);
        chk("t2_done", {19'd0, DONE}, 20'h0);
        tick(0, 1, 0, '0, 0);
        chk("t2_wrap_off", {19'd0, WRAP}, 20'h0);

        // countdown to zero
        tick(0, 0, 1, 20'h00012, 0);
        for (int i = 0; i < 11; i++) tick(1, 0, 0, '0, 0);
        chk("t3_one", now_time(), 20'h00001);
        chk("t3_done_lo", {19'd0, DONE}, 20'h0);
        tick(1, 0, 0, '0, 0);
        chk("t3_zero", now_time(), 20'h00000);
        chk("t3_done", {19'd0, DONE}, 20'h1);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, '0, 0);
        chk("t3_hold", now_time(), 20'h00000);
        chk("t3_done_hold", {19'd0, DONE}, 20'h1);
        tick(1, 1, 0, '0, 0);
        chk("t3_up", now_time(), 20'h00001);
        chk("t3_done_clr", {19'd0, DONE}, 20'h0);

        // lap capture is pre-increment
        tick(0, 1, 1, 20'h00122, 0);
        tick(1, 1, 0, '0, 0);
        tick(1, 1, 0, '0, 1);
        chk("t4_lap", LAP_TIME, 20'h00123);
        chk("t4_time", now_time(), 20'h00124);
        for (int i = 0; i < 50; i++) tick(1, 1, 0, '0, 0);
        chk("t4_lap_hold", LAP_TIME, 20'h00123);

        // sanitised load, CE discarded
        tick(1, 1, 1, {8'h75, 4'h7, 4'hC, 4'h3}, 0);
        chk("t5_san", now_time(), 20'h59593);
        tick(0, 1, 1, {8'h99, 4'h5, 4'h9, 4'hF}, 1);
        chk("t5_san2", now_time(), 20'h59599);
        chk("t5_lap_old", LAP_TIME, 20'h59593);

        // asynchronous clear mid-count
        tick(0, 1, 1, 20'h03274, 0);
        tick(1, 1, 0, '0, 1);
        chk("t6_pre", now_time(), 20'h03275);
        LAP = 0;
        #2 CLR = 1;
        #1;
        chk("t6_time", now_time(), 20'h00000);
        chk("t6_lap", LAP_TIME, 20'h00000);
        chk("t6_done", {19'd0, DONE}, 20'h0);
        #3 CLR = 0;
        tick(1, 1, 0, '0, 0);
        chk("t6_restart", now_time(), 20'h00001);

        // randomised run
        for (int i = 0; i < 4000; i++) begin
            logic [19:0] lv;
            lv = 20'($urandom);
            if ($urandom_range(0, 3) == 0) lv = 20'($urandom_range(0, 40));
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 3, lv,
                 $urandom_range(0, 99) < 5);
        end

        armed = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_cnt.md
Name: stopwatch_cnt

Overview:
Parametrised BCD stopwatch/timer counter: optional tenths digit, seconds 00-59, and a minutes field of configurable digit count and limit.
Supports count-up (stopwatch) and count-down (timer) modes, synchronous preset load, and a lap-capture register.
Sits between the clock-enable divider and the display/mux logic.
Generalised successor of the fixed 9:59 seconds/minutes counter.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1 or 2); MINUTES width = 4*MIN_DIGITS.
MIN_LIMIT, 59, maximum minute value (decimal, <= 10**MIN_DIGITS-1).
TENTHS_EN, 1, 1 = include tenths digit (CE expected at 10 Hz); 0 = tenths forced 0 and seconds LSB counts on CE.
TW, 12+4*MIN_DIGITS, derived packed-time width: {MINUTES, SEC_MSB, SEC_LSB, TENTHS}.

Ports:
CLK  in  1  clock, rising edge.
CLR  in  1  asynchronous active-high reset.
CE  in  1  count enable, one tick per CLK when high.
UP  in  1  1 = count up, 0 = count down.
LOAD  in  1  synchronous preset strobe.
LOAD_VAL  in  TW  packed BCD preset value.
LAP  in  1  lap-capture strobe.
TENTHS  out  4  tenths digit (0 when TENTHS_EN=0).
SEC_LSB  out  4  seconds units 0-9.
SEC_MSB  out  4  seconds tens 0-5, upper bit always 0.
MINUTES  out  4*MIN_DIGITS  BCD minutes 0..MIN_LIMIT.
LAP_TIME  out  TW  captured packed time.
WRAP  out  1  one-cycle pulse on up-count rollover MAX -> 0.
DONE  out  1  level, down-count reached/held at zero.

Behaviour:
- CLR=1: all digits, LAP_TIME, WRAP and DONE are 0 immediately, regardless of clock.
- Per-edge priority: LOAD > CE count. LAP is independent of both.
- LOAD:
  - Next-cycle outputs equal LOAD_VAL after sanitising: any digit >9 becomes 9; SEC_MSB >5 becomes 5; minutes >MIN_LIMIT become MIN_LIMIT.
  - Clears DONE and WRAP. The CE tick in that cycle is discarded.
- Up count (CE=1, UP=1), ripple through the chain tenths -> sec_lsb -> sec_msb -> minutes:
  - tenths wraps 9->0 and carries.
  - sec_lsb wraps 9->0 and carries.
  - sec_msb wraps 5->0 and carries.
  - minutes wrap at MIN_LIMIT to 0.
  - All carries are combinational from the current value within the same CE tick, so the visible increment is always exactly 1 LSB per tick.
  - Full rollover (MAX -> all zero) asserts WRAP for exactly one cycle.
  - Up-count clears DONE.
- Down count (CE=1, UP=0):
  - Mirror borrow chain: tenths 0->9, sec_lsb 0->9, sec_msb 0->5, minutes 0->MIN_LIMIT, each with borrow.
  - If the value is all zero: no decrement, DONE=1; counter holds.
  - A transition 00:01 -> 00:00 sets DONE on the same edge the value reaches zero.
  - Down count never asserts WRAP.
- DONE:
  - Stays high while the value is zero and UP=0.
  - Cleared by LOAD, CLR, or any up-count tick.
- LAP:
  - LAP_TIME captures the value present before this edge's update (pre-increment).
  - LAP coincident with LOAD captures the old value.
  - LAP_TIME holds otherwise.
- UP may change on any cycle; it is sampled with CE on each edge, with no pipeline.
- Latency: one CLK from CE/LOAD to output change. Outputs are registered except SEC_MSB bit 3, which is tied 0.
- CE=0 and LOAD=0: all counters hold; WRAP=0.
- CLR mid-count or mid-load: aborts; counting resumes from 0 on the first edge after CLR deasserts.

Decomposition:
- Package stopwatch_pkg:
  - BCD_MAX_9=4'd9, BCD_MAX_5=4'd5 constants.
  - Packed-time field offsets (TENTHS_LO, SECL_LO, SECM_LO, MIN_LO).
  - Function sanitising a BCD digit against a max.
- Sub-module bcd_digit:
  - Inputs: CLK, CLR, en, up, load, load_val, max.
  - Outputs: q, carry/borrow-out (combinational: en & (up ? q==max : q==0)).
  - Instantiated for tenths, seconds units, seconds tens and each minute digit.
- Minute limit checks are applied across the minute digits in the top level.

Test Plan:
1. Reset, UP=1, CE high for 600 ticks (TENTHS_EN=1) -> 1:00.0 shown (MINUTES=0x01, SEC=00, TENTHS=0); no WRAP.
2. LOAD_VAL=59:59.9, UP=1, one CE -> all digits 0, WRAP high exactly one cycle, DONE=0.
3. LOAD 00:01.2, UP=0, 12 CE ticks -> reaches 00:00.0 with DONE=1 on that edge; 5 further CE ticks -> value holds 0, DONE stays 1; then one UP=1 tick -> 00:00.1, DONE=0.
4. LAP pulse at 00:12.3 with CE=1 -> LAP_TIME=00:12.3 while outputs show 00:12.4; LAP_TIME unchanged after 50 more ticks.
5. LOAD_VAL with SEC_MSB=7, SEC_LSB=0xC, MINUTES=0x75 -> outputs 59:59.x sanitised; LOAD and CE in the same cycle -> no increment.
6. CLR asserted asynchronously mid-cycle while counting at 03:27.5 -> outputs, LAP_TIME and DONE are 0 before the next CLK edge; the count restarts from 0 after release.
